dem_pop_decim: RTL and testbench
================================

Name: dem_pop_decim

Overview:
- Receive-side counterpart to the dual-channel DSM + DEM path.
- Takes the two 16-bit unit-element vectors that the DEM scrambler produces (dem_out_l, dem_out_r) once per 4-cycle DEM frame.
- Decodes each vector back to a signed 5-bit DSM level by popcount, then integrate-and-dump decimates each channel by DECIM.
- Delivers paired L/R words over a valid/ready interface for bit-true comparison against the DSM input stream and for the on-chip level monitor.

Parameters:
- DECIM, 64, decimation ratio in DEM frames; power of two, 2..1024.
- ACC_W, 11, accumulator/output width; must be >= 5+log2(DECIM).

Ports:
- mclk512  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dem_count  in  2  DEM frame phase counter; value 2'b01 marks a valid vector pair.
- dem_out_l  in  16  left unit-element vector (any bit order).
- dem_out_r  in  16  right unit-element vector.
- exchangeLR  in  1  1 = swap L/R at capture.
- dsm_clr  in  1  synchronous clear of the datapath (same effect as reset, except for stat_frames).
- out_l  out  ACC_W  signed decimated left sum.
- out_r  out  ACC_W  signed decimated right sum.
- out_valid  out  1  output word pair valid.
- out_ready  in  1  sink accepts the pair when out_valid&&out_ready.
- overrun  out  1  sticky; a dump was lost because the output was still held.
- stat_frames  out  16  free-running count of captured frames; wraps at 65535->0.

Behaviour:
- Reset (reset=1 at a clock edge):
  - all registers clear; out_l=0, out_r=0, out_valid=0, overrun=0, stat_frames=0.
  - Sample counter and pipeline valids are 0.
  - Reset mid-accumulation discards the partial sums.
- dsm_clr=1: same as reset for all state except stat_frames, which keeps counting. Reset has priority over dsm_clr.
- Capture (edge E0):
  - On the edge where dem_count==2'b01, register both vectors.
  - If exchangeLR=1, left takes dem_out_r and right takes dem_out_l.
  - stat_frames increments on E0.
- Decode (edge E1):
  - level = popcount(vector) - 8, giving a signed 5-bit value in -8..+8.
  - 16 ones -> +8; 0 ones -> -8; 8 ones -> 0.
- Accumulate/dump (edge E2):
  - When k < DECIM-1 (k = frame index within the window): acc <= acc + level; k <= k+1.
  - When k == DECIM-1: dump value = acc + level; acc <= 0; k <= 0.
  - Arithmetic is ACC_W-bit two's complement, sign-extended; no saturation is needed because |sum| <= 8*DECIM fits.
- Output register:
  - A dump loads out_l/out_r and sets out_valid=1 after E2.
  - Latency is 2 cycles from the capture edge of the last frame in the window.
  - Strobes are 4 cycles apart, so the pipeline stages never collide.
- Handshake:
  - out_l, out_r and out_valid hold stable while out_valid=1 && out_ready=0.
  - Transfer when out_valid && out_ready at an edge; out_valid drops next cycle unless a dump lands on the same edge.
  - Dump with no valid output pending, or a dump on the same edge as a transfer: load the new data, out_valid stays 1, no overrun.
  - Dump while out_valid=1 && out_ready=0: the new pair is discarded, old data is kept, overrun<=1.
  - Accumulation continues regardless of output stall.
  - overrun is cleared only by reset or dsm_clr.
- dem_count values other than 01: no capture. A missing or irregular strobe only delays the window; frames are counted, not cycles.
- X/unknown on dem_out_* outside the strobe edge is ignored.

Test Plan:
- DECIM=4; left all-ones, right all-zeros for 4 frames, out_ready=1 -> out_l=+32, out_r=-32; out_valid pulses 1 cycle, 2 cycles after the 4th strobe edge.
- DECIM=4; left alternates 0xFFFF/0x0000, right constant 0x00FF and 0xA5A5 (8 ones) -> out_l=0, out_r=0. Repeat with 0x0001 (1 one) on right -> out_r=-28.
- Default DECIM=64, exchangeLR=1; dem_out_l=0xFFFF, dem_out_r=0x0000 -> out_l=-512, out_r=+512 on an 11-bit word, exactly one valid per 256 cycles.
- out_ready=0 across two windows -> first pair held unchanged, overrun=1 after the second dump. Then out_ready=1 -> transfer; overrun stays 1 until dsm_clr.
- out_ready asserted on exactly the edge of the next dump -> new data loaded, out_valid stays 1, overrun stays 0.
- Assert reset for 1 cycle mid-window (k=2 of 4) -> all outputs 0; the next dump covers exactly 4 fresh frames. dsm_clr instead -> same result, but stat_frames is not cleared.

Source files
------------

// File: rtl/dem_pop_decim.sv
// Popcount decoder and integrate-and-dump decimator for the dual-channel DEM
// unit-element vectors, delivering paired L/R sums over a valid/ready port.
module dem_pop_decim #(
    parameter int DECIM = 64,
    parameter int ACC_W = 11
) (
    input  logic                    mclk512,
    input  logic                    reset,
    input  logic [1:0]              dem_count,
    input  logic [15:0]             dem_out_l,
    input  logic [15:0]             dem_out_r,
    input  logic                    exchangeLR,
    input  logic                    dsm_clr,
    output logic signed [ACC_W-1:0] out_l,
    output logic signed [ACC_W-1:0] out_r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic [15:0]             stat_frames
);

    localparam int            K_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(DECIM - 1);

    logic strobe;
    logic clear;

    assign strobe = (dem_count == 2'b01);
    assign clear  = reset | dsm_clr;

    // Unit-element count mapped onto the signed DSM level: 0 ones -> -8, 16 ones -> +8.
    function automatic logic signed [4:0] unit_level(input logic [15:0] vec);
        logic [4:0] ones;
        ones = '0;
        for (int i = 0; i < 16; i++) begin
            ones = ones + 5'(vec[i]);
        end
        return $signed(ones - 5'd8);
    endfunction

    // ------------------------------------------------------------------
    // E0: capture the vector pair on the frame strobe
    // ------------------------------------------------------------------
    logic        cap_vld;
    logic [15:0] cap_l;
    logic [15:0] cap_r;

    // NOTE: sequential state is written with non-blocking assignments so every
    // stage samples the previous stage's value from before this edge.
    always_ff @(posedge mclk512) begin
        if (clear) begin
            cap_vld <= 1'b0;
            cap_l   <= '0;
            cap_r   <= '0;
        end else begin
            cap_vld <= strobe;
            if (strobe) begin
                cap_l <= exchangeLR ? dem_out_r : dem_out_l;
                cap_r <= exchangeLR ? dem_out_l : dem_out_r;
            end
        end
    end

    // Frame statistics survive dsm_clr; only a full reset zeroes them.
    always_ff @(posedge mclk512) begin
        if (reset) begin
            stat_frames <= '0;
        end else if (strobe) begin
            stat_frames <= stat_frames + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // E1: decode each vector to a signed level
    // ------------------------------------------------------------------
    logic              lvl_vld;
    logic signed [4:0] lvl_l;
    logic signed [4:0] lvl_r;

    always_ff @(posedge mclk512) begin
        if (clear) begin
            lvl_vld <= 1'b0;
            lvl_l   <= '0;
            lvl_r   <= '0;
        end else begin
            lvl_vld <= cap_vld;
            if (cap_vld) begin
                lvl_l <= unit_level(cap_l);
                lvl_r <= unit_level(cap_r);
            end
        end
    end

    // ------------------------------------------------------------------
    // E2: integrate, and dump at the last frame of the window
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;
    logic        [K_W-1:0]   k;
    logic signed [ACC_W-1:0] sum_l;
    logic signed [ACC_W-1:0] sum_r;
    logic                    dump;

    assign sum_l = acc_l + {{(ACC_W-5){lvl_l[4]}}, lvl_l};
    assign sum_r = acc_r + {{(ACC_W-5){lvl_r[4]}}, lvl_r};
    assign dump  = lvl_vld && (k == K_LAST);

    always_ff @(posedge mclk512) begin
        if (clear) begin
            acc_l <= '0;
            acc_r <= '0;
            k     <= '0;
        end else if (lvl_vld) begin
            if (dump) begin
                acc_l <= '0;
                acc_r <= '0;
                k     <= '0;
            end else begin
                acc_l <= sum_l;
                acc_r <= sum_r;
                k     <= k + K_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output holding register with valid/ready handshake
    // ------------------------------------------------------------------
    logic load;
    logic lost;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        load = 1'b0;
        lost = 1'b0;
        if (dump) begin
            if (out_valid && !out_ready) begin
                lost = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk512) begin
        if (clear) begin
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_l     <= sum_l;
                out_r     <= sum_r;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (lost) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dem_pop_decim.sv
// Bench for dem_pop_decim: a DECIM=4 and a default DECIM=64 instance share
// stimulus and are compared every cycle against a frame-level reference model.
module tb_dem_pop_decim;

    logic        clk = 1'b0;
    logic        reset;
    logic        dsm_clr;
    logic        exch;
    logic        out_ready;
    logic [1:0]  dem_count;
    logic [15:0] dl;
    logic [15:0] dr;

    logic signed [6:0]  a_l, a_r;
    logic               a_valid, a_ovr;
    logic [15:0]        a_frames;
    logic signed [10:0] b_l, b_r;
    logic               b_valid, b_ovr;
    logic [15:0]        b_frames;

    always #5 clk = ~clk;

    dem_pop_decim #(.DECIM(4), .ACC_W(7)) u_a (
        .mclk512(clk), .reset(reset), .dem_count(dem_count),
        .dem_out_l(dl), .dem_out_r(dr), .exchangeLR(exch), .dsm_clr(dsm_clr),
        .out_l(a_l), .out_r(a_r), .out_valid(a_valid), .out_ready(out_ready),
        .overrun(a_ovr), .stat_frames(a_frames)
    );

    dem_pop_decim u_b (
        .mclk512(clk), .reset(reset), .dem_count(dem_count),
        .dem_out_l(dl), .dem_out_r(dr), .exchangeLR(exch), .dsm_clr(dsm_clr),
        .out_l(b_l), .out_r(b_r), .out_valid(b_valid), .out_ready(out_ready),
        .overrun(b_ovr), .stat_frames(b_frames)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: frames are summed per window; a completed window
    // becomes a pending dump that reaches the output two edges later.
    int m_dec[2] = '{4, 64};
    int m_sum_l[2], m_sum_r[2], m_cnt[2];
    bit m_pv[2];
    int m_pdue[2], m_pl[2], m_pr[2];
    int m_ol[2], m_or[2];
    bit m_val[2], m_ovr[2];
    int m_frames;
    int cyc = 0;
    int b_valid_cnt = 0;

    task automatic model_edge();
        bit stb;
        int lv_l, lv_r;
        stb = (dem_count == 2'b01);
        for (int i = 0; i < 2; i++) begin
            if (reset || dsm_clr) begin
                m_sum_l[i] = 0; m_sum_r[i] = 0; m_cnt[i] = 0; m_pv[i] = 0;
                m_ol[i] = 0; m_or[i] = 0; m_val[i] = 0; m_ovr[i] = 0;
            end else begin
                if (m_pv[i] && m_pdue[i] == cyc) begin
                    m_pv[i] = 0;
                    if (m_val[i] && !out_ready) begin
                        m_ovr[i] = 1;
                    end else begin
                        m_ol[i] = m_pl[i]; m_or[i] = m_pr[i]; m_val[i] = 1;
                    end
                end else if (m_val[i] && out_ready) begin
                    m_val[i] = 0;
                end
                if (stb) begin
                    lv_l = $countones(exch ? dr : dl) - 8;
                    lv_r = $countones(exch ? dl : dr) - 8;
                    m_sum_l[i] += lv_l;
                    m_sum_r[i] += lv_r;
                    m_cnt[i]++;
                    if (m_cnt[i] == m_dec[i]) begin
                        m_pv[i] = 1; m_pdue[i] = cyc + 2;
                        m_pl[i] = m_sum_l[i]; m_pr[i] = m_sum_r[i];
                        m_sum_l[i] = 0; m_sum_r[i] = 0; m_cnt[i] = 0;
                    end
                end
            end
        end
        if (reset) m_frames = 0;
        else if (stb) m_frames = (m_frames + 1) % 65536;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (b_valid) b_valid_cnt++;
        check("a_out_l", int'(a_l), m_ol[0]);
        check("a_out_r", int'(a_r), m_or[0]);
        check("a_valid", int'(a_valid), int'(m_val[0]));
        check("a_overrun", int'(a_ovr), int'(m_ovr[0]));
        check("a_frames", int'(a_frames), m_frames);
        check("b_out_l", int'(b_l), m_ol[1]);
        check("b_out_r", int'(b_r), m_or[1]);
        check("b_valid", int'(b_valid), int'(m_val[1]));
        check("b_overrun", int'(b_ovr), int'(m_ovr[1]));
        check("b_frames", int'(b_frames), m_frames);
    endtask

    // One 4-cycle DEM frame; rdy[p] drives out_ready during phase p.
    task automatic frame(input logic [15:0] l, input logic [15:0] r, input logic [3:0] rdy);
        for (int p = 0; p < 4; p++) begin
            dem_count = 2'(p);
            out_ready = rdy[p];
            if (p == 1) begin
                dl = l; dr = r;
            end else begin
                dl = 'x; dr = 'x;
            end
            tick();
        end
    endtask

    task automatic idle(input logic rdy);
        dem_count = 2'b00; out_ready = rdy; dl = 'x; dr = 'x;
        tick();
    endtask

    task automatic clr_tick();
        dsm_clr = 1'b1;
        idle(1'b1);
        dsm_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dsm_clr = 1'b0; exch = 1'b0; out_ready = 1'b1;
        dem_count = 2'b00; dl = '0; dr = '0;
        idle(1'b1);
        idle(1'b1);
        reset = 1'b0;
        check("rst_a_l", int'(a_l), 0);
        check("rst_a_valid", int'(a_valid), 0);
        check("rst_frames", int'(a_frames), 0);

        // Full-scale left, zero-scale right.
        for (int f = 0; f < 4; f++) frame(16'hFFFF, 16'h0000, 4'hF);
        check("A_l", int'(a_l), 32);
        check("A_r", int'(a_r), -32);
        check("A_valid", int'(a_valid), 1);
        idle(1'b1);
        check("A_pulse", int'(a_valid), 0);

        // Balanced patterns decode to zero; a single one gives -7 per frame.
        for (int f = 0; f < 4; f++) frame(f[0] ? 16'h0000 : 16'hFFFF, 16'h00FF, 4'hF);
        check("B1_l", int'(a_l), 0);
        check("B1_r", int'(a_r), 0);
        for (int f = 0; f < 4; f++) frame(f[0] ? 16'h0000 : 16'hFFFF, 16'hA5A5, 4'hF);
        check("B2_r", int'(a_r), 0);
        for (int f = 0; f < 4; f++) frame(f[0] ? 16'h0000 : 16'hFFFF, 16'h0001, 4'hF);
        check("B3_l", int'(a_l), 0);
        check("B3_r", int'(a_r), -28);

        // Default-size instance with channel exchange.
        clr_tick();
        exch = 1'b1;
        b_valid_cnt = 0;
        for (int f = 0; f < 64; f++) frame(16'hFFFF, 16'h0000, 4'hF);
        check("C_b_l", int'(b_l), -512);
        check("C_b_r", int'(b_r), 512);
        check("C_a_l", int'(a_l), -32);
        for (int f = 0; f < 64; f++) frame(16'hFFFF, 16'h0000, 4'hF);
        check("C_b_valid_count", b_valid_cnt, 2);
        exch = 1'b0;

        // Stall across two windows.
        clr_tick();
        for (int f = 0; f < 4; f++) frame(16'hFFFF, 16'h0000, 4'h0);
        check("D_first_l", int'(a_l), 32);
        for (int f = 0; f < 4; f++) frame(16'h0000, 16'hFFFF, 4'h0);
        check("D_held_l", int'(a_l), 32);
        check("D_held_r", int'(a_r), -32);
        check("D_overrun", int'(a_ovr), 1);
        idle(1'b1);
        check("D_xfer_valid", int'(a_valid), 0);
        check("D_overrun_sticky", int'(a_ovr), 1);
        clr_tick();
        check("D_overrun_clr", int'(a_ovr), 0);

        // Ready arrives on exactly the edge of the next dump.
        for (int f = 0; f < 4; f++) frame(16'h0FFF, 16'h0007, 4'h0);
        check("E_first_l", int'(a_l), 16);
        check("E_first_r", int'(a_r), -20);
        for (int f = 0; f < 4; f++) frame(16'h0001, 16'hFFFF, (f == 3) ? 4'b1000 : 4'b0000);
        check("E_new_l", int'(a_l), -28);
        check("E_new_r", int'(a_r), 32);
        check("E_valid", int'(a_valid), 1);
        check("E_overrun", int'(a_ovr), 0);

        // Reset mid-window discards the partial sum.
        clr_tick();
        for (int f = 0; f < 2; f++) frame(16'h0000, 16'h0000, 4'hF);
        reset = 1'b1;
        idle(1'b1);
        reset = 1'b0;
        check("F_rst_l", int'(a_l), 0);
        check("F_rst_frames", int'(a_frames), 0);
        for (int f = 0; f < 4; f++) frame(16'hFFFF, 16'hFFFF, 4'hF);
        check("F_fresh_l", int'(a_l), 32);
        check("F_fresh_r", int'(a_r), 32);
        for (int f = 0; f < 2; f++) frame(16'h0000, 16'h0000, 4'hF);
        clr_tick();
        check("F_clr_frames", int'(a_frames), 6);
        for (int f = 0; f < 4; f++) frame(16'hFFFF, 16'hFFFF, 4'hF);
        check("F_clr_fresh_l", int'(a_l), 32);

        // Randomized: irregular strobes, random data, stalls, exchange and clears.
        for (int n = 0; n < 3000; n++) begin
            dem_count = 2'($urandom_range(0, 3));
            dl = 16'($urandom);
            dr = 16'($urandom);
            exch = 1'($urandom_range(0, 1));
            out_ready = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            dsm_clr = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; dsm_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
